single_inv_half_adder: RTL and testbench
========================================

// Module: single_inv_half_adder
// PURPOSE
//  Half adder whose A operand enters inverted: each lane adds (~inv_a) + b.
//  Used in the Booth-4 / Wallace-tree 16x16 multiplier to compress
//  sign-extension and inverted partial-product bits.
//  WIDTH independent lanes, with an optional output register stage.
// PARAMETERS
//  WIDTH    1  number of independent 1-bit lanes
//  REG_OUT  0  0 = combinational outputs; 1 = outputs registered on sys_clk
// PORTS
//  sys_clk    in   1      clock; used only when REG_OUT=1
//  sys_rst    in   1      asynchronous, active-high reset
//  in_valid   in   1      qualifies inv_a/b; tie 1 in combinational use
//  inv_a      in   WIDTH  operand A, inverted inside the block before adding
//  b          in   WIDTH  operand B, true polarity
//  sum        out  WIDTH  per-lane sum bit: ~inv_a[i] ^ b[i]
//  cout       out  WIDTH  per-lane carry bit: ~inv_a[i] & b[i]
//  out_valid  out  1      qualifies sum/cout
//  cout_any   out  1      OR-reduction of cout
// BEHAVIOUR
//  - One clock (sys_clk). Reset is asynchronous and active-high (sys_rst).
//  - Per lane: {cout,sum} = (1 - inv_a) + b, as a 2-bit result.
//    inv_a b : cout sum
//      0   0 :   0   1
//      0   1 :   1   0
//      1   0 :   0   0
//      1   1 :   0   1
//  - Lanes are independent. There is no carry chain between lanes.
//  - REG_OUT=0:
//    - Pure combinational path, zero latency.
//    - out_valid = in_valid.
//    - sys_clk and sys_rst have no effect and may be left unconnected.
//  - REG_OUT=1:
//    - Latency is 1 cycle. On each rising edge, registers load the lane
//      results of the current inputs, and out_valid <= in_valid.
//    - Registers load every cycle whatever in_valid is; out_valid is only
//      a flag and does not gate the load.
//    - sys_rst asserted: sum, cout, cout_any and out_valid go to 0
//      immediately, without waiting for a clock edge.
//    - sys_rst asserted in mid-operation drops the in-flight result.
//    - After reset releases, the first rising edge loads the current inputs.
//  - cout_any = |cout. It is taken from cout after registering, so it has
//    the same latency as cout.
//  - There is no X-propagation handling. With any X input, the affected
//    lane output is X.
// TESTING
//  1. REG_OUT=0, WIDTH=1; hold each input pair 20 ns:
//     {inv_a,b}=00 -> sum=1, cout=0
//     {inv_a,b}=01 -> sum=0, cout=1
//     {inv_a,b}=10 -> sum=0, cout=0
//     {inv_a,b}=11 -> sum=1, cout=0
//  2. REG_OUT=0, WIDTH=4:
//     inv_a=4'b0011, b=4'b0101 -> sum=4'b1001, cout=4'b0100, cout_any=1
//  3. REG_OUT=1, WIDTH=1; apply {inv_a,b}=01, in_valid=1:
//     outputs stay at old values until the next edge; after that edge
//     sum=0, cout=1, out_valid=1
//  4. REG_OUT=1; outputs loaded as in test 3; assert sys_rst between edges:
//     sum, cout and out_valid = 0 with no clock edge;
//     outputs hold 0 while sys_rst stays high
//  5. REG_OUT=1, WIDTH=4; inv_a=4'hF, b=4'hF:
//     one edge later sum=4'hF, cout=4'h0, cout_any=0
//  6. Exhaustive check, WIDTH=2, all 16 input patterns:
//     compare each lane against (1 - inv_a) + b, for both REG_OUT values

Source files
------------

// File: rtl/single_inv_half_adder.sv
// Half adder with inverted A operand: per lane {cout,sum} = (1 - inv_a) + b.
// Independent lanes; optional single output register stage on sys_clk.
module single_inv_half_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REG_OUT = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inv_a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             out_valid,
  output logic             cout_any
);

  localparam logic USE_REG = (REG_OUT != 0);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] cout_d, cout_q;
  logic             out_valid_d, out_valid_q;
  logic             cout_any_d, cout_any_q;

  // Lane arithmetic; no carry crosses lanes.
  always_comb begin
    sum_d       = ~inv_a ^ b;
    cout_d      = ~inv_a & b;
    out_valid_d = in_valid;
    cout_any_d  = |cout_d;
  end

  // Registers load every cycle; in_valid only travels alongside as a flag.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sum_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
      cout_any_q  <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      cout_any_q  <= cout_any_d;
    end
  end

  // Registers are pruned by synthesis when the combinational path is selected.
  always_comb begin
    sum       = USE_REG ? sum_q       : sum_d;
    cout      = USE_REG ? cout_q      : cout_d;
    out_valid = USE_REG ? out_valid_q : out_valid_d;
    cout_any  = USE_REG ? cout_any_q  : cout_any_d;
  end

endmodule

// File: tb/tb_single_inv_half_adder.sv
// Directed bench for single_inv_half_adder across combinational and registered builds.
module tb_single_inv_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       v;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic [1:0] a2, b2;

  logic       c1_sum, c1_cout, c1_ov, c1_any;
  logic       r1_sum, r1_cout, r1_ov, r1_any;
  logic [3:0] c4_sum, c4_cout, r4_sum, r4_cout;
  logic       c4_ov, c4_any, r4_ov, r4_any;
  logic [1:0] c2_sum, c2_cout, r2_sum, r2_cout;
  logic       c2_ov, c2_any, r2_ov, r2_any;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  single_inv_half_adder #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a1), .b(b1),
    .sum(c1_sum), .cout(c1_cout), .out_valid(c1_ov), .cout_any(c1_any));
  single_inv_half_adder #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a1), .b(b1),
    .sum(r1_sum), .cout(r1_cout), .out_valid(r1_ov), .cout_any(r1_any));
  single_inv_half_adder #(.WIDTH(4), .REG_OUT(0)) u_c4 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a4), .b(b4),
    .sum(c4_sum), .cout(c4_cout), .out_valid(c4_ov), .cout_any(c4_any));
  single_inv_half_adder #(.WIDTH(4), .REG_OUT(1)) u_r4 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a4), .b(b4),
    .sum(r4_sum), .cout(r4_cout), .out_valid(r4_ov), .cout_any(r4_any));
  single_inv_half_adder #(.WIDTH(2), .REG_OUT(0)) u_c2 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a2), .b(b2),
    .sum(c2_sum), .cout(c2_cout), .out_valid(c2_ov), .cout_any(c2_any));
  single_inv_half_adder #(.WIDTH(2), .REG_OUT(1)) u_r2 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(v), .inv_a(a2), .b(b2),
    .sum(r2_sum), .cout(r2_cout), .out_valid(r2_ov), .cout_any(r2_any));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] t1_sum;
    logic [3:0] t1_cout;
    logic [1:0] es, ec;
    int         r;

    t1_sum  = 4'b1001;
    t1_cout = 4'b0010;

    rst = 1'b1; v = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0; a2 = '0; b2 = '0;
    #1;
    check("rst_r1_sum", 8'(r1_sum), 8'h0);
    check("rst_r1_cout", 8'(r1_cout), 8'h0);
    check("rst_r1_ov", 8'(r1_ov), 8'h0);
    check("rst_r4_any", 8'(r4_any), 8'h0);
    check("rst_r4_sum", 8'(r4_sum), 8'h0);

    // Combinational truth table, 20 ns per pair
    @(negedge clk); rst = 1'b0; v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #20;
      check($sformatf("t1_sum_%0d", i), 8'(c1_sum), 8'(t1_sum[i]));
      check($sformatf("t1_cout_%0d", i), 8'(c1_cout), 8'(t1_cout[i]));
      check($sformatf("t1_ov_%0d", i), 8'(c1_ov), 8'h1);
    end

    // Combinational 4-lane
    a4 = 4'b0011; b4 = 4'b0101; #1;
    check("t2_sum", 8'(c4_sum), 8'h9);
    check("t2_cout", 8'(c4_cout), 8'h4);
    check("t2_any", 8'(c4_any), 8'h1);

    // Registered: preload old value {00} with in_valid low
    @(negedge clk); a1 = 1'b0; b1 = 1'b0; v = 1'b0;
    @(posedge clk); #1;
    check("t3_pre_sum", 8'(r1_sum), 8'h1);
    check("t3_pre_ov", 8'(r1_ov), 8'h0);
    @(negedge clk); a1 = 1'b0; b1 = 1'b1; v = 1'b1; #1;
    check("t3_hold_sum", 8'(r1_sum), 8'h1);
    check("t3_hold_cout", 8'(r1_cout), 8'h0);
    check("t3_hold_ov", 8'(r1_ov), 8'h0);
    @(posedge clk); #1;
    check("t3_sum", 8'(r1_sum), 8'h0);
    check("t3_cout", 8'(r1_cout), 8'h1);
    check("t3_ov", 8'(r1_ov), 8'h1);
    check("t3_r4_any", 8'(r4_any), 8'h1);

    // Async reset between edges
    @(negedge clk); #2; rst = 1'b1; #1;
    check("t4_sum", 8'(r1_sum), 8'h0);
    check("t4_cout", 8'(r1_cout), 8'h0);
    check("t4_ov", 8'(r1_ov), 8'h0);
    check("t4_r4_any", 8'(r4_any), 8'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_held_cout", 8'(r1_cout), 8'h0);
    check("t4_held_ov", 8'(r1_ov), 8'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t4_rel_cout", 8'(r1_cout), 8'h1);
    check("t4_rel_ov", 8'(r1_ov), 8'h1);
    check("t4_rel_r4_cout", 8'(r4_cout), 8'h4);

    // Load happens regardless of in_valid
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; v = 1'b0;
    @(posedge clk); #1;
    check("nv_sum", 8'(r1_sum), 8'h1);
    check("nv_cout", 8'(r1_cout), 8'h0);
    check("nv_ov", 8'(r1_ov), 8'h0);

    // Registered 4-lane, all ones
    @(negedge clk); a4 = 4'hF; b4 = 4'hF; v = 1'b1; #1;
    check("t5_pre_any", 8'(r4_any), 8'h1);
    @(posedge clk); #1;
    check("t5_sum", 8'(r4_sum), 8'hF);
    check("t5_cout", 8'(r4_cout), 8'h0);
    check("t5_any", 8'(r4_any), 8'h0);
    check("t5_ov", 8'(r4_ov), 8'h1);

    // Exhaustive 2-lane, both builds, against (1 - a) + b
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      a2 = 2'(p >> 2); b2 = 2'(p);
      for (int l = 0; l < 2; l++) begin
        r = 1 - int'(a2[l]) + int'(b2[l]);
        es[l] = r[0];
        ec[l] = r[1];
      end
      #1;
      check($sformatf("t6c_sum_%0d", p), 8'(c2_sum), 8'(es));
      check($sformatf("t6c_cout_%0d", p), 8'(c2_cout), 8'(ec));
      check($sformatf("t6c_any_%0d", p), 8'(c2_any), 8'(|ec));
      @(posedge clk); #1;
      check($sformatf("t6r_sum_%0d", p), 8'(r2_sum), 8'(es));
      check($sformatf("t6r_cout_%0d", p), 8'(r2_cout), 8'(ec));
      check($sformatf("t6r_any_%0d", p), 8'(r2_any), 8'(|ec));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
